// File: rtl/mem_resp_4c.sv
// Word-addressed 16-bit memory with a fixed-latency, in-order read return pipeline.
// Reads snapshot storage at issue and surface LATENCY cycles later as a one-cycle pulse.
module mem_resp_4c #(
  parameter int LATENCY = 4,
  parameter int ADDR_W  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        wr,
  input  logic [15:0] addr,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic [3:0]  rd_inflight
);

  localparam int DEPTH = 1 << ADDR_W;

  // Handshake: enable is a fire-and-forget strobe, accepted every cycle with no
  // back-pressure; data_valid is a one-cycle pulse the requester must take as it comes.
  logic [15:0]        mem [DEPTH];
  logic [ADDR_W-1:0]  word_idx;
  logic               rd_issue;
  logic               rd_retire;
  logic [LATENCY-1:0] pipe_valid;
  logic [15:0]        pipe_data [LATENCY];

  assign word_idx  = addr[ADDR_W:1];
  assign rd_issue  = enable && !wr;
  assign rd_retire = pipe_valid[LATENCY-1];

  // Storage is deliberately untouched by reset; only the writes are held off.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_valid  <= '0;
      rd_inflight <= 4'd0;
      for (int i = 0; i < LATENCY; i++) begin
        pipe_data[i] <= 16'h0000;
      end
    end else begin
      if (enable && wr) begin
        mem[word_idx] <= data_in;
      end
      pipe_valid[0] <= rd_issue;
      pipe_data[0]  <= rd_issue ? mem[word_idx] : 16'h0000;
      for (int i = 1; i < LATENCY; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_data[i]  <= pipe_data[i-1];
      end
      case ({rd_issue, rd_retire})
        2'b10:   rd_inflight <= rd_inflight + 4'd1;
        2'b01:   rd_inflight <= rd_inflight - 4'd1;
        default: rd_inflight <= rd_inflight;
      endcase
    end
  end

  assign data_valid = pipe_valid[LATENCY-1];
  assign data_out   = data_valid ? pipe_data[LATENCY-1] : 16'h0000;

endmodule

// File: doc/mem_resp_4c.md
MEM_RESP_4C -- requirements
Module: mem_resp_4c

Interface
REQ-001 SHALL have parameter LATENCY, default 4, meaning read-issue-to-data_valid delay in clock cycles; legal range 1..8.
REQ-002 SHALL have parameter ADDR_W, default 15, meaning width of the word index, giving 2^ADDR_W 16-bit words of storage.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  input  1  request strobe; one request accepted per cycle when high.
REQ-006 SHALL have port wr  input  1  qualifies enable: 1 = write request, 0 = read request.
REQ-007 SHALL have port addr  input  16  byte address; the word index is addr[ADDR_W:1], and addr[0] is ignored.
REQ-008 SHALL have port data_in  input  16  write data, sampled with an enabled write.
REQ-009 SHALL have port data_out  output  16  read return data, valid only when data_valid is high.
REQ-010 SHALL have port data_valid  output  1  one-cycle pulse per returned read word.
REQ-011 SHALL have port rd_inflight  output  4  count of accepted reads not yet returned.

Function
REQ-012 SHALL always accept requests: no ready/stall output; the requester (cache-fill FSM) may issue a new request every cycle.
REQ-013 SHALL perform an enabled write (enable=1, wr=1) into storage at the clock edge where it is sampled; a write produces no data_valid.
REQ-014 SHALL snapshot read data at the issue edge for an enabled read (enable=1, wr=0), then carry it through a LATENCY-deep shift pipeline of {valid, data}.
REQ-015 SHALL raise data_valid exactly LATENCY cycles after the issue edge: a read issued at edge N gives data_valid=1 in the cycle after edge N+LATENCY-1, for one cycle.
REQ-016 SHALL return reads strictly in issue order; back-to-back reads produce back-to-back data_valid pulses, one per read.
REQ-017 SHALL drive data_out to 16'h0000 in every cycle where data_valid is 0.
REQ-018 SHALL apply read-after-write ordering: a read issued any cycle after a write to the same word returns the written data.
REQ-019 SHALL leave a read unaffected by a later write to the same word before its return, because the data was snapshotted at issue.
REQ-020 SHALL treat cycles with enable=0 as idle; the pipeline still advances by one stage.
REQ-021 SHALL update rd_inflight each edge as +1 for an issued read and -1 for a retiring read; simultaneous issue and retire leave it unchanged.
REQ-022 SHALL bound rd_inflight at LATENCY by construction; no overflow handling is needed.
REQ-023 SHALL leave storage contents undefined until written.
REQ-024 SHALL need no wrap-around handling: addresses above 2^(ADDR_W+1)-1 alias through truncation of the index.

Reset
REQ-025 SHALL, while rst_n=0, force data_valid=0, data_out=16'h0000, rd_inflight=0, and clear every pipeline valid bit, asynchronously.
REQ-026 SHALL discard in-flight reads when reset is asserted mid-operation; none produce data_valid after release.
REQ-027 SHALL leave storage contents unchanged by reset.
REQ-028 SHALL ignore requests while rst_n=0 and accept new requests from the first rising edge after rst_n rises.

Verification
REQ-029 SHALL cover single read latency: write 16'hBEEF to addr 16'h0010, then read it -> data_valid high exactly 4 cycles after the read edge with data_out=16'hBEEF, and rd_inflight stepping 1,1,1,1,0.
REQ-030 SHALL cover a burst: write words 16'h1111..16'h4444 to 16'h0020..16'h0026, then issue 4 consecutive reads -> 4 consecutive data_valid pulses in order 1111, 2222, 3333, 4444, with rd_inflight peaking at 4.
REQ-031 SHALL cover the snapshot hazard: read 16'h0010 (holding BEEF), then write 16'h1234 to 16'h0010 on the next cycle -> first return is BEEF; a subsequent read returns 1234.
REQ-032 SHALL cover odd address: write 16'hA5A5 at 16'h0031, read at 16'h0030 -> returns A5A5.
REQ-033 SHALL cover reset mid-flight: issue 3 reads, assert rst_n=0 for 1 cycle after 2 edges -> no data_valid afterwards, rd_inflight=0, and earlier-written data still readable.
REQ-034 SHALL cover LATENCY=1 build: a read returns data_valid on the cycle after issue, and continuous reads give continuous valid.
